// File: rtl/nubus_timeout_responder.sv
// NuBus bus-timeout responder: tracks every /START, and if no card
// acknowledges within 2^TIMEOUT_W cycles it drives a one-cycle timeout /ACK.
//
// Ports:
//   nub_clk, nub_reset                 clock, sync active-high reset
//   enable                             1 = may drive, 0 = monitor only
//   nub_startn_i, nub_ackn_i           sampled /START, /ACK
//   nub_tm1n_i, nub_tm0n_i, nub_adn_i  sampled /TM1, /TM0, /AD
//   nub_ack_oe, nub_ackn_o,
//   nub_tm1n_o, nub_tm0n_o             timeout acknowledge drive
//   err_valid, err_addr, err_write,
//   err_mode, err_count                timeout log for software
//   busy                               a transfer is being tracked
module nubus_timeout_responder #(
  parameter int TIMEOUT_W = 8,
  parameter int ERRCNT_W  = 16
) (
  input  logic                nub_clk,
  input  logic                nub_reset,
  input  logic                enable,
  input  logic                nub_startn_i,
  input  logic                nub_ackn_i,
  input  logic                nub_tm1n_i,
  input  logic                nub_tm0n_i,
  input  logic [31:0]         nub_adn_i,
  output logic                nub_ack_oe,
  output logic                nub_ackn_o,
  output logic                nub_tm1n_o,
  output logic                nub_tm0n_o,
  output logic                err_valid,
  output logic [31:0]         err_addr,
  output logic                err_write,
  output logic [1:0]          err_mode,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic                 capture;
  logic                 fire;
  logic [31:0]          sh_addr_q;
  logic [1:0]           sh_mode_q;

  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // /ACK on the terminal count cycle wins over the timeout.
  // A /START seen while not IDLE is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!nub_startn_i && nub_ackn_i) begin
          state_d = WAIT;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (!nub_ackn_i) begin
          state_d = IDLE;
        end else if (&cnt_q) begin
          state_d = enable ? ACK : IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fire = (state_d == ACK);

  // Outputs are registered from the next state so the drive lines up
  // exactly with the ACK state.
  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      nub_ack_oe <= 1'b0;
      nub_ackn_o <= 1'b1;
      nub_tm1n_o <= 1'b1;
      nub_tm0n_o <= 1'b1;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_write  <= 1'b0;
      err_mode   <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
      sh_addr_q  <= '0;
      sh_mode_q  <= '0;
    end else begin
      nub_ack_oe <= fire;
      nub_ackn_o <= !fire;
      nub_tm1n_o <= !fire;
      nub_tm0n_o <= 1'b1;
      err_valid  <= fire;
      busy       <= (state_d != IDLE);
      if (capture) begin
        sh_addr_q <= ~nub_adn_i;
        sh_mode_q <= {~nub_tm1n_i, ~nub_tm0n_i};
      end
      if (fire) begin
        err_addr  <= sh_addr_q;
        err_write <= sh_mode_q[1];
        err_mode  <= sh_mode_q;
        if (!(&err_count)) begin
          err_count <= err_count + ERRCNT_W'(1);
        end
      end
    end
  end

endmodule
